conv33_window_gen: RTL and testbench
====================================

Name: conv33_window_gen

Overview:
- Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution stage.
- Accepts one DATA_W-bit pixel per handshake in raster order (row-major, IMG_W x IMG_H frame).
- Buffers the two previous rows in line memories and presents each fully-inside 3x3 neighbourhood as nine parallel taps.
- The taps feed the convolver's nine data inputs. No padding: (IMG_H-2)*(IMG_W-2) windows per frame.

Parameters:
- DATA_W, 6, pixel width in bits.
- IMG_W, 8, pixels per row; must be >= 3.
- IMG_H, 8, rows per frame; must be >= 3.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_in  in  DATA_W  input pixel
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block can accept pixel
- win_0 .. win_8  out  DATA_W each  window taps, row-major: win_0 top-left (r-2,c-2), win_4 centre (r-1,c-1), win_8 bottom-right (r,c)
- win_valid  out  1  window taps valid
- win_ready  in  1  downstream accepts window
- win_last  out  1  qualifies the final window of a frame

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Accept: a pixel is accepted when pix_valid && pix_ready.
- Ready: pix_ready = !win_valid || win_ready. This is a single output register stage with no extra buffering, so at most one window is held.
- Reset values: win_valid=0, win_last=0, win_0..win_8=0, col=0, row=0, column shift registers=0. Line-memory contents are not reset; they are don't-care because validity is position-gated.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accept. col wraps to 0 and increments row. After (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame starts with no idle cycle required.
- Line memories lb_top[IMG_W] and lb_mid[IMG_W] are indexed by col. On accept at col c:
  - read taps T=lb_top[c] and M=lb_mid[c];
  - write lb_top[c] <= lb_mid[c] and lb_mid[c] <= pix_in.
- Column shift: three 3-deep shift registers (top, mid, bottom rows) shift on accept, taking T, M and pix_in respectively. They are not cleared at row start; the c>=2 gating covers this.
- Output register: on accept of pixel (r,c) with r>=2 && c>=2:
  - load win_0..8 from the shift registers after the shift;
  - set win_valid=1;
  - set win_last=1 iff r==IMG_H-1 && c==IMG_W-1.
- Latency: window appears the cycle after the accept of its bottom-right pixel.
- Clear: if the accept is not window-producing and win_ready was high (or the output was empty), win_valid goes 0. If no accept and win_ready is high, win_valid goes 0.
- Stall: while win_valid && !win_ready, the window taps, win_valid and win_last hold stable, and no pixel is accepted.
- Simultaneous win_ready and accept: the old window retires and the new one loads in the same cycle; full throughput is 1 window/cycle.
- pix_valid gaps: no state changes and the output holds its handshake rules.
- Reset mid-frame: output cleared and counters return to (0,0); the next accepted pixel is treated as (0,0) of a new frame.
- Arithmetic: pure data movement with no width change. Counters are $clog2 of IMG_W and IMG_H.

Optional Feature:
- Macro CONV33_WIN_SOF_EN.
- Defined: adds input pix_sof (1 bit). An accepted pixel with pix_sof=1 is forced to position (0,0); counters restart from it. The output register is not flushed, so a pending window still drains normally. A pixel with pix_sof=1 at (0,0) already is a no-op resync.
- Undefined: port absent; position is derived purely from counters.

Test Plan:
- 4x4 frame (IMG_W=IMG_H=4), pixels 0..15, pix_valid=1, win_ready=1 -> exactly 4 windows. First is 0,1,2,4,5,6,8,9,10 one cycle after pixel 10. Last is 5,6,7,9,10,11,13,14,15 with win_last=1; win_last=0 on the others.
- Same frame with win_ready held low 3 cycles while the first window is valid -> taps and win_valid stable, pix_ready=0 throughout, no pixel lost; all 4 windows are correct and in order.
- Random pix_valid gaps (~50% duty) over two back-to-back 4x4 frames (second frame = pixel value+16) -> 8 windows. The second frame's first window is 16,17,18,20,21,22,24,25,26.
- rst asserted for 1 cycle after pixel 7, then full 4x4 frame 0..15 -> win_valid=0 the cycle after reset; the following frame yields the same 4 windows as the first scenario.
- Default 8x8 frame, continuous stream, win_ready=1 -> 36 windows at 1/cycle within each row (c>=2), none in rows 0-1. win_last only on the window ending at pixel 63.
- CONV33_WIN_SOF_EN: send 5 junk pixels, then a 4x4 frame with pix_sof=1 on pixel 0 -> windows match the first scenario exactly.

Source files
------------

// File: rtl/conv33_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv33_window_gen.
// With CONV33_WIN_SOF_EN defined, the bundle also carries pix_sof.
interface conv33_window_gen_if #(
    parameter int DATA_W = 6
);
    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic              pix_ready;
`ifdef CONV33_WIN_SOF_EN
    logic              pix_sof;
`endif
    logic [DATA_W-1:0] win_0;
    logic [DATA_W-1:0] win_1;
    logic [DATA_W-1:0] win_2;
    logic [DATA_W-1:0] win_3;
    logic [DATA_W-1:0] win_4;
    logic [DATA_W-1:0] win_5;
    logic [DATA_W-1:0] win_6;
    logic [DATA_W-1:0] win_7;
    logic [DATA_W-1:0] win_8;
    logic              win_valid;
    logic              win_ready;
    logic              win_last;

`ifdef CONV33_WIN_SOF_EN
    modport master (
        output pix_in, pix_valid, pix_sof, win_ready,
        input  pix_ready, win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8,
        input  win_valid, win_last
    );
    modport slave (
        input  pix_in, pix_valid, pix_sof, win_ready,
        output pix_ready, win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8,
        output win_valid, win_last
    );
`else
    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8,
        input  win_valid, win_last
    );
    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8,
        output win_valid, win_last
    );
`endif
endinterface

// File: rtl/conv33_window_gen.sv
// Streaming 3x3 window generator: two line memories, three 3-deep column shifters, one output register.
// Optional macro CONV33_WIN_SOF_EN: accepted pixel with pix_sof=1 is forced to position (0,0).
module conv33_window_gen #(
    parameter int DATA_W = 6,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic               clk,
    input  logic               rst,
    conv33_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_reg, col_next, col_pos;
    logic [RW-1:0] row_reg, row_next, row_pos;

    logic [DATA_W-1:0] lb_top [IMG_W];
    logic [DATA_W-1:0] lb_mid [IMG_W];
    logic [DATA_W-1:0] row_in [3];

    // Index 0 is the oldest column (c-2), index 2 the newest (c).
    logic [2:0][DATA_W-1:0] sh_reg  [3];
    logic [2:0][DATA_W-1:0] sh_next [3];

    logic [8:0][DATA_W-1:0] win_reg, win_next;
    logic win_valid_reg, win_valid_next;
    logic win_last_reg, win_last_next;

    logic accept;
    logic sof;
    logic produce;

`ifdef CONV33_WIN_SOF_EN
    assign sof = bus.pix_sof;
`else
    assign sof = 1'b0;
`endif

    assign bus.pix_ready = !win_valid_reg || bus.win_ready;
    assign accept        = bus.pix_valid && bus.pix_ready;

    assign col_pos = sof ? '0 : col_reg;
    assign row_pos = sof ? '0 : row_reg;
    assign produce = (row_pos >= RW'(2)) && (col_pos >= CW'(2));

    assign row_in[0] = lb_top[col_pos];
    assign row_in[1] = lb_mid[col_pos];
    assign row_in[2] = bus.pix_in;

    // Line memories carry no reset: every read that reaches an output is position-gated.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[col_pos] <= lb_mid[col_pos];
            lb_mid[col_pos] <= bus.pix_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            assign sh_next[gi] = {row_in[gi], sh_reg[gi][2], sh_reg[gi][1]};

            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_reg[gi] <= '0;
                end else if (accept) begin
                    sh_reg[gi] <= sh_next[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        col_next       = col_reg;
        row_next       = row_reg;
        win_next       = win_reg;
        win_valid_next = win_valid_reg;
        win_last_next  = win_last_reg;

        if (accept) begin
            if (col_pos == COL_LAST) begin
                col_next = '0;
                row_next = (row_pos == ROW_LAST) ? '0 : row_pos + RW'(1);
            end else begin
                col_next = col_pos + CW'(1);
                row_next = row_pos;
            end
        end

        // An accept implies the output was empty or retiring, so both paths below are safe.
        if (accept && produce) begin
            win_next       = {sh_next[2], sh_next[1], sh_next[0]};
            win_valid_next = 1'b1;
            win_last_next  = (row_pos == ROW_LAST) && (col_pos == COL_LAST);
        end else if (bus.win_ready) begin
            win_valid_next = 1'b0;
            win_last_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg       <= '0;
            row_reg       <= '0;
            win_reg       <= '0;
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
        end else begin
            col_reg       <= col_next;
            row_reg       <= row_next;
            win_reg       <= win_next;
            win_valid_reg <= win_valid_next;
            win_last_reg  <= win_last_next;
        end
    end

    assign bus.win_0     = win_reg[0];
    assign bus.win_1     = win_reg[1];
    assign bus.win_2     = win_reg[2];
    assign bus.win_3     = win_reg[3];
    assign bus.win_4     = win_reg[4];
    assign bus.win_5     = win_reg[5];
    assign bus.win_6     = win_reg[6];
    assign bus.win_7     = win_reg[7];
    assign bus.win_8     = win_reg[8];
    assign bus.win_valid = win_valid_reg;
    assign bus.win_last  = win_last_reg;
endmodule

// File: tb/tb_conv33_window_gen.sv
// Scoreboard bench for conv33_window_gen: a 4x4 instance and a default 8x8 instance.
`timescale 1ns/1ps
module tb_conv33_window_gen;
    localparam int DW = 6;
    localparam int WB = 9 * DW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    conv33_window_gen_if #(.DATA_W(DW)) ifa ();
    conv33_window_gen_if #(.DATA_W(DW)) ifb ();

    conv33_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    conv33_window_gen #(.DATA_W(DW), .IMG_W(8), .IMG_H(8)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;

    logic [WB-1:0] exp_a[$], exp_b[$], seen_a[$], seen_b[$];
    int cyc_a[$], cyc_b[$];
    int acc_cyc_a [64];
    logic [WB-1:0] act_a, act_b, exp_pop_a, exp_pop_b;

    function automatic logic [WB-1:0] get_a();
        return {ifa.win_last, ifa.win_8, ifa.win_7, ifa.win_6, ifa.win_5, ifa.win_4,
                ifa.win_3, ifa.win_2, ifa.win_1, ifa.win_0};
    endfunction

    function automatic logic [WB-1:0] get_b();
        return {ifb.win_last, ifb.win_8, ifb.win_7, ifb.win_6, ifb.win_5, ifb.win_4,
                ifb.win_3, ifb.win_2, ifb.win_1, ifb.win_0};
    endfunction

    function automatic logic [WB-1:0] pack9(input logic last, input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
        return {last, DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    // Reference window whose bottom-right pixel is (r,c); pixel value is r*w+c+off.
    function automatic logic [WB-1:0] mkwin(input int w, input int h, input int r, input int c, input int off);
        logic [WB-1:0] res;
        res = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                res[(i*3+j)*DW +: DW] = DW'((r-2+i)*w + (c-2+j) + off);
        res[WB-1] = (r == h-1) && (c == w-1);
        return res;
    endfunction

    task automatic push_frame(input bit b, input int off);
        int w;
        w = b ? 8 : 4;
        for (int r = 2; r < w; r++)
            for (int c = 2; c < w; c++)
                if (b) exp_b.push_back(mkwin(w, w, r, c, off));
                else   exp_a.push_back(mkwin(w, w, r, c, off));
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.win_valid && ifa.win_ready) begin
            act_a = get_a();
            seen_a.push_back(act_a);
            cyc_a.push_back(cyc);
            n_cmp++;
            if (exp_a.size() == 0) begin
                n_bad++;
                $display("FAIL win_a_unexpected: got %0h expected none", act_a);
            end else begin
                exp_pop_a = exp_a.pop_front();
                if (act_a !== exp_pop_a) begin
                    n_bad++;
                    $display("FAIL win_a: got %0h expected %0h (t=%0t)", act_a, exp_pop_a, $time);
                end else begin
                    $display("win_a ok %0h at cycle %0d", act_a, cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.win_valid && ifb.win_ready) begin
            act_b = get_b();
            seen_b.push_back(act_b);
            cyc_b.push_back(cyc);
            n_cmp++;
            if (exp_b.size() == 0) begin
                n_bad++;
                $display("FAIL win_b_unexpected: got %0h expected none", act_b);
            end else begin
                exp_pop_b = exp_b.pop_front();
                if (act_b !== exp_pop_b) begin
                    n_bad++;
                    $display("FAIL win_b: got %0h expected %0h (t=%0t)", act_b, exp_pop_b, $time);
                end else begin
                    $display("win_b ok %0h at cycle %0d", act_b, cyc);
                end
            end
        end
    end

    // Called right after a posedge (+1); returns the same way once the pixel is accepted.
    task automatic send(input bit b, input int v, input logic sof, input int gap, input int idx);
        int  t;
        bit  ok;
        if (b) ifb.pix_valid = 1'b0; else ifa.pix_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        if (b) begin
            ifb.pix_in = DW'(v);
            ifb.pix_valid = 1'b1;
        end else begin
            ifa.pix_in = DW'(v);
            ifa.pix_valid = 1'b1;
`ifdef CONV33_WIN_SOF_EN
            ifa.pix_sof = sof;
`endif
        end
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = b ? ifb.pix_ready : ifa.pix_ready;
            if (ok && !b && idx >= 0) acc_cyc_a[idx] = cyc;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
`ifdef CONV33_WIN_SOF_EN
        ifa.pix_sof = 1'b0;
`endif
    endtask

    task automatic drain(input bit b);
        int t;
        t = 0;
        if (b) ifb.pix_valid = 1'b0; else ifa.pix_valid = 1'b0;
        while ((b ? exp_b.size() : exp_a.size()) > 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(b ? "drain_b" : "drain_a", 64'(b ? exp_b.size() : exp_a.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic stall_first();
        int t;
        t = 0;
        @(negedge clk);
        while (!ifa.win_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_valid", 64'(ifa.win_valid), 64'd1);
            chk("stall_taps", 64'(get_a()), 64'(pack9(1'b0, 0, 1, 2, 4, 5, 6, 8, 9, 10)));
            chk("stall_pix_ready", 64'(ifa.pix_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ifa.win_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.pix_in = '0; ifa.pix_valid = 1'b0; ifa.win_ready = 1'b1;
        ifb.pix_in = '0; ifb.pix_valid = 1'b0; ifb.win_ready = 1'b1;
`ifdef CONV33_WIN_SOF_EN
        ifa.pix_sof = 1'b0;
        ifb.pix_sof = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        @(negedge clk);
        chk("reset_valid_a", 64'(ifa.win_valid), 64'd0);
        chk("reset_last_a", 64'(ifa.win_last), 64'd0);
        chk("reset_taps_a", 64'(get_a()), 64'd0);
        chk("reset_ready_a", 64'(ifa.pix_ready), 64'd1);
        chk("reset_valid_b", 64'(ifb.win_valid), 64'd0);
        @(posedge clk);
        #1;

        // Continuous 4x4 frame.
        seen_a.delete(); cyc_a.delete();
        push_frame(1'b0, 0);
        for (int i = 0; i < 16; i++) send(1'b0, i, 1'b0, 0, i);
        drain(1'b0);
        chk("s1_count", 64'(seen_a.size()), 64'd4);
        if (seen_a.size() == 4) begin
            chk("s1_first", 64'(seen_a[0]), 64'(pack9(1'b0, 0, 1, 2, 4, 5, 6, 8, 9, 10)));
            chk("s1_last", 64'(seen_a[3]), 64'(pack9(1'b1, 5, 6, 7, 9, 10, 11, 13, 14, 15)));
            chk("s1_latency", 64'(cyc_a[0]), 64'(acc_cyc_a[10] + 1));
        end

        // Same frame with the first window stalled for three cycles.
        seen_a.delete(); cyc_a.delete();
        push_frame(1'b0, 0);
        ifa.win_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(1'b0, i, 1'b0, 0, i);
            end
            stall_first();
        join
        drain(1'b0);
        chk("s2_count", 64'(seen_a.size()), 64'd4);

        // Two back-to-back frames with random input gaps.
        seen_a.delete(); cyc_a.delete();
        push_frame(1'b0, 0);
        push_frame(1'b0, 16);
        for (int i = 0; i < 32; i++) send(1'b0, i, 1'b0, $urandom_range(0, 2), -1);
        drain(1'b0);
        chk("s3_count", 64'(seen_a.size()), 64'd8);
        if (seen_a.size() == 8)
            chk("s3_frame2_first", 64'(seen_a[4]), 64'(pack9(1'b0, 16, 17, 18, 20, 21, 22, 24, 25, 26)));

        // Reset mid-frame after pixel 7, then a full frame.
        seen_a.delete(); cyc_a.delete();
        for (int i = 0; i < 8; i++) send(1'b0, 40 + i, 1'b0, 0, -1);
        ifa.pix_valid = 1'b0;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("s4_valid_after_rst", 64'(ifa.win_valid), 64'd0);
        chk("s4_taps_after_rst", 64'(get_a()), 64'd0);
        @(posedge clk);
        #1;
        push_frame(1'b0, 0);
        for (int i = 0; i < 16; i++) send(1'b0, i, 1'b0, 0, i);
        drain(1'b0);
        chk("s4_count", 64'(seen_a.size()), 64'd4);
        if (seen_a.size() == 4)
            chk("s4_last", 64'(seen_a[3]), 64'(pack9(1'b1, 5, 6, 7, 9, 10, 11, 13, 14, 15)));

        // Default 8x8 continuous frame.
        seen_b.delete(); cyc_b.delete();
        push_frame(1'b1, 0);
        for (int i = 0; i < 64; i++) send(1'b1, i, 1'b0, 0, -1);
        drain(1'b1);
        chk("s5_count", 64'(seen_b.size()), 64'd36);
        if (seen_b.size() == 36) begin
            for (int k = 0; k < 35; k++)
                if (k % 6 != 5) chk("s5_rate", 64'(cyc_b[k+1]), 64'(cyc_b[k] + 1));
            chk("s5_last", 64'(seen_b[35]), 64'(pack9(1'b1, 45, 46, 47, 53, 54, 55, 61, 62, 63)));
        end

`ifdef CONV33_WIN_SOF_EN
        // Junk pixels, then a frame that resynchronises with pix_sof.
        seen_a.delete(); cyc_a.delete();
        push_frame(1'b0, 0);
        for (int i = 0; i < 5; i++) send(1'b0, 50 + i, 1'b0, 0, -1);
        for (int i = 0; i < 16; i++) send(1'b0, i, i == 0, 0, i);
        drain(1'b0);
        chk("s6_count", 64'(seen_a.size()), 64'd4);
        if (seen_a.size() == 4)
            chk("s6_first", 64'(seen_a[0]), 64'(pack9(1'b0, 0, 1, 2, 4, 5, 6, 8, 9, 10)));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
